// File: rtl/slide.sv
// Player slide (duck) controller.
// On an accepted slide request the sprite height steps down to SLIDE_H, stays
// there for HOLD_TICKS frame ticks, then steps back up to STAND_H. Everything
// advances only on the one-clock frame strobe. Entry is gated by the jump
// FSM's is_jumping signal so a slide never starts mid-jump.
module slide #(
  parameter int WIDTH      = 12,
  parameter int STAND_H    = 60,
  parameter int SLIDE_H    = 20,
  parameter int STEP       = 10,
  parameter int HOLD_TICKS = 30,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             down,
  input  logic             blocked,
  output logic [WIDTH-1:0] height,
  output logic             is_sliding,
  output logic             slide_done
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] DUCK = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;
  localparam logic [1:0] RISE = 2'd3;

  localparam logic [WIDTH-1:0] STAND_V   = WIDTH'(STAND_H);
  localparam logic [WIDTH-1:0] SLIDE_V   = WIDTH'(SLIDE_H);
  localparam logic [WIDTH:0]   STEP_X    = (WIDTH+1)'(STEP);
  localparam logic [WIDTH:0]   STAND_X   = (WIDTH+1)'(STAND_H);
  localparam logic [WIDTH:0]   SLIDE_X   = (WIDTH+1)'(SLIDE_H);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_TICKS - 1);

  logic [1:0]       state;
  logic [CNT_W-1:0] hold_cnt;

  // The last downward step lands on the floor. The comparison is done one bit
  // wider so SLIDE_H+STEP cannot wrap, and a height already within one step of
  // the floor snaps to it rather than undershooting (or wrapping below zero).
  function automatic logic duck_at_floor(input logic [WIDTH-1:0] h);
    return ({1'b0, h} <= (SLIDE_X + STEP_X));
  endfunction

  function automatic logic [WIDTH-1:0] duck_next(input logic [WIDTH-1:0] h);
    if (duck_at_floor(h)) return SLIDE_V;
    return h - WIDTH'(STEP);
  endfunction

  // The upward step saturates at STAND_H; the sum is formed in WIDTH+1 bits
  // so it cannot overflow before the comparison.
  function automatic logic rise_at_top(input logic [WIDTH-1:0] h);
    return (({1'b0, h} + STEP_X) >= STAND_X);
  endfunction

  function automatic logic [WIDTH-1:0] rise_next(input logic [WIDTH-1:0] h);
    logic [WIDTH:0] sum;
    sum = {1'b0, h} + STEP_X;
    if (rise_at_top(h)) return STAND_V;
    return sum[WIDTH-1:0];
  endfunction

  // Slide FSM, height and hold counter; all progress gated by the frame tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      height     <= STAND_V;
      hold_cnt   <= '0;
      slide_done <= 1'b0;
    end else begin
      slide_done <= 1'b0;
      if (tick) begin
        case (state)
          IDLE: begin
            height <= STAND_V;
            if (down && !blocked) state <= DUCK;
          end
          DUCK: begin
            height <= duck_next(height);
            if (duck_at_floor(height)) begin
              hold_cnt <= '0;
              state    <= HOLD;
            end
          end
          HOLD: begin
            if (hold_cnt == HOLD_LAST) state <= RISE;
            else                       hold_cnt <= hold_cnt + 1'b1;
          end
          RISE: begin
            height <= rise_next(height);
            if (rise_at_top(height)) begin
              state      <= IDLE;
              slide_done <= 1'b1;
            end
          end
          default: begin
            state    <= IDLE;
            height   <= STAND_V;
            hold_cnt <= '0;
          end
        endcase
      end
    end
  end

  // Busy flag comes straight from the registered state.
  always_comb begin
    is_sliding = (state != IDLE);
  end

endmodule
